leak_mult_arbiter: RTL
======================

LEAK_MULT_ARBITER -- requirements
Module: leak_mult_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 8, meaning the number of neuron requesters sharing one multiplier (range 2..32).
REQ-002 The block SHALL have parameter WIDTH, default pa_SnnAccelerator::FP_WIDTH, meaning the fixed-point operand/result width.
REQ-003 The block SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port en  input  1  arbitration enable; when low, no new grants are issued and in-flight results still complete.
REQ-006 The block SHALL have port req_valid  input  N_REQ  per-requester multiply request.
REQ-007 The block SHALL have port req_a  input  N_REQ*WIDTH  flattened operand A, slice i = [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_b  input  N_REQ*WIDTH  flattened operand B, same slicing.
REQ-009 The block SHALL have port req_ready  output  N_REQ  one-hot or zero grant.
REQ-010 The block SHALL have port rsp_valid  output  N_REQ  one-hot or zero result strobe.
REQ-011 The block SHALL have port rsp_result  output  WIDTH  signed product, quantized to WIDTH.
REQ-012 The block SHALL have port rsp_overflow  output  1  overflow flag of the product.
REQ-013 The block SHALL have port busy  output  1  high while any accepted request is in flight.

Function
REQ-014 Arbitration SHALL be round-robin: grant the lowest index i, searching ptr..N_REQ-1 then wrapping to 0..ptr-1, with req_valid[i]=1.
REQ-015 req_ready SHALL be combinational from req_valid, ptr, en and rst, and SHALL be 0 whenever en=0 or rst=1.
REQ-016 A transfer SHALL occur when req_valid[i] & req_ready[i]; at most one transfer SHALL occur per cycle, giving a throughput of 1 multiply/cycle.
REQ-017 After a transfer from index g, ptr SHALL become g+1, wrapping from N_REQ-1 to 0; with no transfer, ptr SHALL hold.
REQ-018 Requesters SHALL hold req_valid and their operands stable until granted; the block SHALL NOT latch unaccepted requests.
REQ-019 On transfer, the operands and the one-hot requester tag SHALL be registered into stage S1; the product SHALL be computed combinationally from S1.
REQ-020 Without the macro (REQ-027), rsp_valid[g], rsp_result and rsp_overflow SHALL be driven from S1 in the cycle after the transfer (latency 1).
REQ-021 Responses SHALL have no backpressure; rsp_valid SHALL pulse for exactly one cycle per transfer, and responses SHALL return in grant order.
REQ-022 The product SHALL be signed fixed-point with the same format, quantization and overflow semantics as qmult; rsp_result and rsp_overflow SHALL be 0 when rsp_valid=0.
REQ-023 busy SHALL equal the OR of all pipeline-stage valid bits.
REQ-024 When en falls during a stream, the last granted transfer SHALL still return its response and ptr SHALL hold.

Reset
REQ-025 With rst=1 at a clock edge, the block SHALL set ptr=0, clear all stage valid bits, and force rsp_valid=0, rsp_result=0, rsp_overflow=0 and busy=0 from the next cycle.
REQ-026 A reset arriving mid-operation SHALL discard all in-flight requests with no response, and a request presented during rst SHALL NOT be granted.

Configuration
REQ-027 Macro LEAK_MULT_ARBITER_RSP_REG_EN: when defined, a second register stage S2 SHALL capture the product, tag and overflow, giving latency 2 at unchanged throughput, and busy SHALL cover S1 and S2; when undefined, latency SHALL be 1 per REQ-020.

Structure
REQ-028 The package pa_SnnAccelerator SHALL own FP_WIDTH and a new constant LEAK_ARB_N_REQ_DEFAULT=8; no other typedefs SHALL be added.
REQ-029 The block SHALL instantiate exactly one qmult sub-module, fed from S1; the round-robin grant logic SHALL stay inline.

Verification
REQ-030 The bench SHALL cover: all 8 req_valid held high for 16 cycles from reset -> grants 0,1,...,7,0,...,7 with one per cycle, and rsp_valid follows each grant by 1 cycle (2 with the macro).
REQ-031 The bench SHALL cover: only requesters 2 and 5 valid and ptr=3 -> grant 5, then 2, then 5, alternating.
REQ-032 The bench SHALL cover: a=potent-potent_rest and b=leakage_cofficient_inhibitory on requester 0 -> rsp_result bit-exact to the qmult model and rsp_overflow=0.
REQ-033 The bench SHALL cover: operands of maximum positive value x2.0 -> rsp_overflow=1 on the response cycle only.
REQ-034 The bench SHALL cover: en dropped after 3 grants with requests still pending -> no further grants, 3 responses, busy falls to 0, and on en=1 granting resumes at ptr=3.
REQ-035 The bench SHALL cover: rst asserted one cycle after a grant -> no rsp_valid appears, ptr=0, and busy=0.

Source files
------------

// File: rtl/leak_mult_arbiter_pkg.sv
// Shared SNN accelerator constants: fixed-point format and the
// default requester count for the leak multiplier arbiter.
package pa_SnnAccelerator;
  localparam int FP_WIDTH               = 16;  // Q8.8 signed
  localparam int FP_FRAC                = 8;
  localparam int LEAK_ARB_N_REQ_DEFAULT = 8;
endpackage

// File: rtl/leak_mult_arbiter_qmult.sv
// qmult: signed fixed-point multiply. The full product is shifted right by
// FRAC with floor rounding. If the result does not fit in W bits, overflow is
// flagged and the result saturates toward the sign of the full product.
module qmult
  import pa_SnnAccelerator::*;
#(
  parameter int W    = FP_WIDTH,
  parameter int FRAC = FP_FRAC
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result,
  output logic         o_overflow
);
  logic signed [2*W-1:0] w_a_ext, w_b_ext, w_full, w_shift;
  logic                  w_hi_ones, w_hi_zeros;

  assign w_a_ext    = {{W{i_a[W-1]}}, i_a};
  assign w_b_ext    = {{W{i_b[W-1]}}, i_b};
  assign w_full     = w_a_ext * w_b_ext;
  assign w_shift    = w_full >>> FRAC;
  // The result fits only if the discarded upper bits are a sign extension.
  assign w_hi_ones  = &w_shift[2*W-1:W-1];
  assign w_hi_zeros = ~|w_shift[2*W-1:W-1];
  assign o_overflow = !(w_hi_ones || w_hi_zeros);

  // Saturate on overflow, otherwise keep the low W bits of the scaled product.
  always_comb begin
    o_result = w_shift[W-1:0];
    if (o_overflow)
      o_result = w_shift[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
endmodule

// File: rtl/leak_mult_arbiter.sv
// leak_mult_arbiter: round-robin share of one qmult among N_REQ neuron
// requesters, one multiply per cycle, responses in grant order.
// Optional macro LEAK_MULT_ARBITER_RSP_REG_EN adds a response register stage.
// Without it, latency is 1. With it, latency is 2.
module leak_mult_arbiter
  import pa_SnnAccelerator::*;
#(
  parameter int N_REQ = LEAK_ARB_N_REQ_DEFAULT,
  parameter int WIDTH = FP_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_overflow,
  output logic                   busy
);
  localparam int PW = $clog2(N_REQ);
`ifdef LEAK_MULT_ARBITER_RSP_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [PW-1:0]    r_ptr;
  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_gnt_idx;
  logic             w_xfer;
  logic [STAGES:1]  r_vld_pipe;
  logic [N_REQ-1:0] r_s1_tag;
  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic [WIDTH-1:0] w_prod;
  logic             w_prod_ovf;
  logic             w_out_vld;
  logic [N_REQ-1:0] w_out_tag;
  logic [WIDTH-1:0] w_out_res;
  logic             w_out_ovf;

  // Round-robin search starting at r_ptr; a grant implies a transfer because
  // grants are only issued to requesters that are valid.
  always_comb begin
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] j;
    w_gnt     = '0;
    w_gnt_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      j = sum[PW-1:0];
      if (!found && req_valid[j]) begin
        found     = 1'b1;
        w_gnt_idx = j;
      end
    end
    w_xfer = found && en && !rst;
    if (w_xfer) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign req_ready = w_gnt;

  // Pointer moves just past the winner; it holds when nothing transfers.
  always_ff @(posedge clk) begin
    if (rst)         r_ptr <= '0;
    else if (w_xfer) r_ptr <= (w_gnt_idx == PW'(N_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
  end

  // Stage valid shift register; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[1] <= w_xfer;
      for (int s = 2; s <= STAGES; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
    end
  end

  // S1 captures the winner's operands and one-hot tag.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_s1_a   <= req_a[w_gnt_idx*WIDTH +: WIDTH];
      r_s1_b   <= req_b[w_gnt_idx*WIDTH +: WIDTH];
      r_s1_tag <= w_gnt;
    end
  end

  qmult #(.W(WIDTH), .FRAC(FP_FRAC)) u_qmult (
    .i_a        (r_s1_a),
    .i_b        (r_s1_b),
    .o_result   (w_prod),
    .o_overflow (w_prod_ovf)
  );

`ifdef LEAK_MULT_ARBITER_RSP_REG_EN
  logic [N_REQ-1:0] r_s2_tag;
  logic [WIDTH-1:0] r_s2_res;
  logic             r_s2_ovf;

  // S2 registers the product so the multiplier path ends at a flop.
  always_ff @(posedge clk) begin
    if (r_vld_pipe[1]) begin
      r_s2_tag <= r_s1_tag;
      r_s2_res <= w_prod;
      r_s2_ovf <= w_prod_ovf;
    end
  end

  assign w_out_vld = r_vld_pipe[2];
  assign w_out_tag = r_s2_tag;
  assign w_out_res = r_s2_res;
  assign w_out_ovf = r_s2_ovf;
`else
  assign w_out_vld = r_vld_pipe[1];
  assign w_out_tag = r_s1_tag;
  assign w_out_res = w_prod;
  assign w_out_ovf = w_prod_ovf;
`endif

  // Responses are zeroed when idle. They are also zeroed during reset, so a
  // response that is in flight when reset arrives is never presented.
  always_comb begin
    rsp_valid    = '0;
    rsp_result   = '0;
    rsp_overflow = 1'b0;
    if (w_out_vld && !rst) begin
      rsp_valid    = w_out_tag;
      rsp_result   = w_out_res;
      rsp_overflow = w_out_ovf;
    end
  end

  assign busy = |r_vld_pipe;
endmodule
